// File: rtl/eth_pcs_blk_lock_if.sv
// Gearbox-to-block-lock sideband: per-block sync header in, lock/slip/invalid status out.
interface eth_pcs_blk_lock_if #(
  parameter int W_SYNC = 2
);
  logic              i_clk_en;
  logic              i_grbx_hdr_valid;
  logic [W_SYNC-1:0] i_grbx_hdr;
  logic              o_blk_lock;
  logic              o_slip;
  logic              o_sh_invalid;
  logic [15:0]       o_slip_cnt;

  modport master (
    output i_clk_en, i_grbx_hdr_valid, i_grbx_hdr,
    input  o_blk_lock, o_slip, o_sh_invalid, o_slip_cnt
  );

  modport slave (
    input  i_clk_en, i_grbx_hdr_valid, i_grbx_hdr,
    output o_blk_lock, o_slip, o_sh_invalid, o_slip_cnt
  );
endinterface

// File: rtl/eth_pcs_blk_lock.sv
// 10GBASE-R 64b/66b block-lock FSM: slips the gearbox until sync headers align.
// Optional saturating slip counter enabled by ETH_PCS_BLK_LOCK_STATS_EN.
module eth_pcs_blk_lock #(
  parameter int W_SYNC           = 2,
  parameter int N_SH_WINDOW      = 64,
  parameter int N_SH_INVALID_MAX = 16,
  parameter int N_SLIP_WAIT      = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  eth_pcs_blk_lock_if.slave  bus
);
  localparam logic [W_SYNC-1:0] SYNC_DATA = W_SYNC'(2'b01);
  localparam logic [W_SYNC-1:0] SYNC_CTRL = W_SYNC'(2'b10);
  localparam int                W_WAIT    = (N_SLIP_WAIT > 1) ? $clog2(N_SLIP_WAIT) : 1;
  localparam logic [6:0]        WIN_END   = 7'(N_SH_WINDOW);
  localparam logic [4:0]        INV_MAX   = 5'(N_SH_INVALID_MAX);
  localparam logic [W_WAIT-1:0] WAIT_LAST = W_WAIT'(N_SLIP_WAIT - 1);

  typedef enum logic {TEST_SH, SLIP_WAIT} state_t;

  state_t            state_q, state_d;
  logic [6:0]        sh_cnt_q, sh_cnt_d, sh_cnt_inc;
  logic [4:0]        inv_cnt_q, inv_cnt_d, inv_cnt_inc;
  logic [W_WAIT-1:0] wait_q, wait_d;
  logic              lock_q, lock_d;
  logic              slip_q, slip_d;
  logic              shinv_q, shinv_d;
  logic              acc, sh_bad;

  assign acc         = bus.i_clk_en && bus.i_grbx_hdr_valid;
  assign sh_bad      = !(bus.i_grbx_hdr == SYNC_DATA || bus.i_grbx_hdr == SYNC_CTRL);
  assign sh_cnt_inc  = sh_cnt_q + 7'd1;
  assign inv_cnt_inc = inv_cnt_q + {4'd0, sh_bad};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= TEST_SH;
      sh_cnt_q  <= '0;
      inv_cnt_q <= '0;
      wait_q    <= '0;
      lock_q    <= 1'b0;
      slip_q    <= 1'b0;
      shinv_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_cnt_q  <= sh_cnt_d;
      inv_cnt_q <= inv_cnt_d;
      wait_q    <= wait_d;
      lock_q    <= lock_d;
      slip_q    <= slip_d;
      shinv_q   <= shinv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_cnt_d  = sh_cnt_q;
    inv_cnt_d = inv_cnt_q;
    wait_d    = wait_q;
    lock_d    = lock_q;
    slip_d    = 1'b0;
    shinv_d   = 1'b0;
    if (acc) begin
      unique case (state_q)
        TEST_SH: begin
          shinv_d = sh_bad;
          // Slip decision outranks the window-end rules on the same header.
          if (sh_bad && (inv_cnt_inc == INV_MAX || !lock_q)) begin
            lock_d  = 1'b0;
            slip_d  = 1'b1;
            wait_d  = '0;
            state_d = SLIP_WAIT;
          end else if (sh_cnt_inc == WIN_END) begin
            if (inv_cnt_inc == 5'd0) lock_d = 1'b1;
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
          end else begin
            sh_cnt_d  = sh_cnt_inc;
            inv_cnt_d = inv_cnt_inc;
          end
        end
        SLIP_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            sh_cnt_d  = '0;
            inv_cnt_d = '0;
            state_d   = TEST_SH;
          end else begin
            wait_d = wait_q + W_WAIT'(1);
          end
        end
        default: state_d = TEST_SH;
      endcase
    end
  end

  assign bus.o_blk_lock   = lock_q;
  assign bus.o_slip       = slip_q;
  assign bus.o_sh_invalid = shinv_q;

`ifdef ETH_PCS_BLK_LOCK_STATS_EN
  logic [15:0] slip_cnt_q;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                             slip_cnt_q <= '0;
    else if (slip_d && slip_cnt_q != 16'hFFFF) slip_cnt_q <= slip_cnt_q + 16'd1;
  end
  assign bus.o_slip_cnt = slip_cnt_q;
`else
  assign bus.o_slip_cnt = '0;
`endif
endmodule

// File: tb/tb_eth_pcs_blk_lock.sv
// Block-lock bench: directed scenarios plus biased random headers against a rule-level model.
module tb_eth_pcs_blk_lock;
  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  always #5 i_clk = ~i_clk;

  eth_pcs_blk_lock_if #(.W_SYNC(2)) bus ();
  eth_pcs_blk_lock dut (.i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bus.slave));

  int n_cmp = 0, n_err = 0;
  int m_lock, m_cnt, m_inv, m_wait, m_slips;
  int e_slip, e_shinv;
  int inv_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_cnt = 0; m_inv = 0; m_wait = 0; m_slips = 0;
    e_slip = 0; e_shinv = 0;
  endtask

  // One accepted-or-not header applied to the rule model.
  task automatic model_hdr(input logic en, input logic v, input logic [1:0] h);
    bit bad;
    e_slip = 0; e_shinv = 0;
    if (!(en && v)) return;
    if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin m_cnt = 0; m_inv = 0; end
      return;
    end
    bad = !(h == 2'b01 || h == 2'b10);
    m_cnt++;
    if (bad) begin m_inv++; e_shinv = 1; end
    if (bad && (m_inv == 16 || m_lock == 0)) begin
      m_lock = 0; e_slip = 1; m_wait = 2;
      if (m_slips < 65535) m_slips++;
    end else if (m_cnt == 64) begin
      if (m_inv == 0) m_lock = 1;
      m_cnt = 0; m_inv = 0;
    end
  endtask

  task automatic check_outs(input string tag);
    int exp_cnt;
`ifdef ETH_PCS_BLK_LOCK_STATS_EN
    exp_cnt = m_slips;
`else
    exp_cnt = 0;
`endif
    chk({tag, ".lock"},  32'(bus.o_blk_lock),   32'(m_lock));
    chk({tag, ".slip"},  32'(bus.o_slip),       32'(e_slip));
    chk({tag, ".shinv"}, 32'(bus.o_sh_invalid), 32'(e_shinv));
    chk({tag, ".scnt"},  32'(bus.o_slip_cnt),   32'(exp_cnt));
  endtask

  task automatic step(input string tag, input logic en, input logic v, input logic [1:0] h);
    @(negedge i_clk);
    bus.i_clk_en = en; bus.i_grbx_hdr_valid = v; bus.i_grbx_hdr = h;
    @(posedge i_clk);
    #1;
    model_hdr(en, v, h);
    if (bus.o_sh_invalid) inv_seen++;
    check_outs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge i_clk);
    #1 i_reset_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_lock"},  32'(bus.o_blk_lock),   32'd0);
    chk({tag, ".rst_slip"},  32'(bus.o_slip),       32'd0);
    chk({tag, ".rst_shinv"}, 32'(bus.o_sh_invalid), 32'd0);
    chk({tag, ".rst_scnt"},  32'(bus.o_slip_cnt),   32'd0);
    bus.i_clk_en = 1'b0; bus.i_grbx_hdr_valid = 1'b0; bus.i_grbx_hdr = 2'b00;
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  initial begin
    int pct;
    logic [1:0] h;
    bus.i_clk_en = 1'b0; bus.i_grbx_hdr_valid = 1'b0; bus.i_grbx_hdr = 2'b00;
    model_reset();
    do_reset("init");

    // 64 good headers lock exactly after the 64th.
    for (int i = 0; i < 63; i++) step("lock64", 1, 1, 2'b01);
    chk("lock64.pre", 32'(bus.o_blk_lock), 32'd0);
    step("lock64", 1, 1, 2'b10);
    chk("lock64.post", 32'(bus.o_blk_lock), 32'd1);

    // Unlocked: bad 5th header slips; next two ignored; then relock.
    do_reset("slip5");
    for (int i = 0; i < 4; i++) step("slip5", 1, 1, 2'b01);
    step("slip5", 1, 1, 2'b11);
    chk("slip5.slip", 32'(bus.o_slip), 32'd1);
    step("slip5.wait", 1, 1, 2'b00);
    step("slip5.wait", 1, 1, 2'b11);
    for (int i = 0; i < 64; i++) step("slip5.relock", 1, 1, 2'b01);
    chk("slip5.locked", 32'(bus.o_blk_lock), 32'd1);

    // Locked: 15 invalids in one window keep lock.
    inv_seen = 0;
    for (int i = 0; i < 64; i++)
      step("inv15", 1, 1, (i % 4 == 0 && i < 60) ? 2'b00 : 2'b01);
    chk("inv15.pulses", 32'(inv_seen), 32'd15);
    chk("inv15.lock", 32'(bus.o_blk_lock), 32'd1);

    // 16th invalid as the 64th header: slip wins over window end.
    for (int i = 0; i < 63; i++)
      step("inv16", 1, 1, (i < 15) ? 2'b11 : 2'b10);
    chk("inv16.held", 32'(bus.o_blk_lock), 32'd1);
    step("inv16.last", 1, 1, 2'b00);
    chk("inv16.drop", 32'(bus.o_blk_lock), 32'd0);
    chk("inv16.slip", 32'(bus.o_slip), 32'd1);
    step("inv16.gap", 0, 0, 2'b01);
    chk("inv16.slip1", 32'(bus.o_slip), 32'd0);

    // Clock enable toggling: only enabled headers count.
    do_reset("clken");
    for (int i = 0; i < 128; i++) step("clken", logic'(i % 2 == 0), 1, 2'b01);
    chk("clken.lock", 32'(bus.o_blk_lock), 32'd1);

    // Async reset while locked, then need a full 64 again.
    do_reset("rstlk");
    for (int i = 0; i < 64; i++) step("rstlk", 1, 1, 2'b01);
    chk("rstlk.lock", 32'(bus.o_blk_lock), 32'd1);

    // Biased random segments.
    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(0, 3))
        0: pct = 0;
        1: pct = 1;
        2: pct = 5;
        default: pct = 30;
      endcase
      if ($urandom_range(0, 19) == 0) do_reset("rnd");
      for (int i = 0; i < 80; i++) begin
        h = ($urandom_range(0, 99) < pct) ? (($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00)
                                          : (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01);
        step("rnd", logic'($urandom_range(0, 9) < 8), logic'($urandom_range(0, 9) < 9), h);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/eth_pcs_blk_lock.md
# eth_pcs_blk_lock

Receive-side 64b/66b block-lock state machine for the 10GBASE-R PCS. It sits between the RX gearbox and the 66/64 decoder, monitors the 2-bit sync headers the gearbox delivers once per block, and commands the gearbox to slip by one bit until header alignment is found. It reports lock to the rest of the PCS and flags every invalid header so a downstream BER monitor can consume it. Behaviour follows the IEEE 802.3 Clause 49 lock state machine: 64 good headers to lock, 16 invalid headers in a 64-header window to lose lock.

## Interface

Parameters:
- `W_SYNC`, 2, sync header width, from `eth_pcs_params`.
- `N_SH_WINDOW`, 64, headers per test window.
- `N_SH_INVALID_MAX`, 16, invalid headers in one window that force loss of lock.
- `N_SLIP_WAIT`, 2, valid headers discarded after each slip while the gearbox realigns.

Ports:
- `i_clk`  in  1  PCS RX clock. This is the only clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_clk_en`  in  1  gearbox clock enable. All state advances only when high.
- `i_grbx_hdr_valid`  in  1  a new block header is present this cycle.
- `i_grbx_hdr`  in  W_SYNC  sync header.
- `o_blk_lock`  out  1  block lock achieved, registered.
- `o_slip`  out  1  one-`i_clk`-cycle request to the gearbox to shift alignment by one bit.
- `o_sh_invalid`  out  1  one-cycle pulse per accepted invalid header, registered.
- `o_slip_cnt`  out  16  saturating slip counter. Exists only under the macro below; otherwise tied to 0.

## Operation

- Header accepted: `i_clk_en && i_grbx_hdr_valid`. Nothing counts or transitions otherwise.
- Header validity:
  - `sh_valid` = header is `SYNC_DATA` (2'b01) or `SYNC_CTRL` (2'b10).
  - 2'b00 and 2'b11 are invalid.
- Counters:
  - `sh_cnt` is 7 bits, range 0..64.
  - `sh_invalid_cnt` is 5 bits, range 0..16.
  - Both increment on every accepted header in TEST_SH.
  - `sh_invalid_cnt` increments only on invalid headers.
- States:
  - TEST_SH. Evaluate each accepted header using the incremented counter values:
    - Invalid header and (`sh_invalid_cnt`==N_SH_INVALID_MAX or !`o_blk_lock`): clear lock, pulse `o_slip`, go to SLIP_WAIT. This has priority over every window-end rule.
    - `sh_cnt`==N_SH_WINDOW and `sh_invalid_cnt`==0: set `o_blk_lock` and clear both counters.
    - `sh_cnt`==N_SH_WINDOW and `sh_invalid_cnt`>0 (lock held): clear both counters. `o_blk_lock` is unchanged.
  - SLIP_WAIT:
    - Discard N_SLIP_WAIT accepted headers, regardless of their value.
    - Then clear both counters and return to TEST_SH.
    - Invalid headers here do not raise `o_sh_invalid`.
- While unlocked, the first invalid header in any window slips immediately.
- While locked, isolated invalid headers (fewer than 16 per window) keep lock.

## Timing

- Reset (asynchronous assert, synchronous deassert handled externally):
  - `o_blk_lock`=0, `o_slip`=0, `o_sh_invalid`=0, `o_slip_cnt`=0.
  - Counters 0, state TEST_SH.
- Latency: a header accepted in cycle N updates `o_blk_lock`, `o_slip` and `o_sh_invalid` at the edge ending cycle N. The new values are visible in cycle N+1.
- `o_slip`:
  - High for exactly one `i_clk` cycle per slip decision.
  - Never high in two consecutive cycles.
  - Not issued again until SLIP_WAIT completes.
- `o_sh_invalid` pulse is one `i_clk` cycle.
- `i_clk_en` low holds all state and counters. Registered pulse outputs still return to 0 on the next cycle.
- `i_grbx_hdr_valid` high while `i_clk_en` is low is ignored.
- Reset mid-SLIP_WAIT or mid-window drops lock immediately and aborts the pending wait.

## Configuration

- Macro `ETH_PCS_BLK_LOCK_STATS_EN`.
- Defined:
  - 16-bit `o_slip_cnt` increments on every `o_slip` pulse and saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined:
  - Counter logic is absent and `o_slip_cnt` is a constant 0.
  - All other behaviour is identical.

## Test plan

- Reset, then 64 consecutive accepted headers of 2'b01 -> `o_blk_lock` rises exactly one cycle after the 64th, with no `o_slip`.
- Unlocked, header 2'b11 as the 5th header -> `o_slip` one cycle later. The next 2 headers are ignored, then 64 good headers -> lock.
- Locked, 15 invalid headers spread across one 64-header window -> lock held, 15 `o_sh_invalid` pulses, counters cleared at the window end.
- Locked, 16th invalid header arrives as header 64 of the window -> `o_blk_lock` falls and `o_slip` pulses, since slip beats the window-end rule. `o_slip_cnt` increments by 1 with the macro defined.
- `i_clk_en` toggling 1/0 with valid asserted every cycle -> only enabled cycles count, and lock arrives after 64 enabled headers.
- `i_reset_n` asserted while locked -> all outputs 0 asynchronously. After release, 64 good headers are needed again to re-lock.
